// File: rtl/cbp_mb_ctrl.sv
// Per-macroblock coded_block_pattern collector and Intra_4x4 CBP ue(v) codeword generator.
// Latency: mb_done_i at edge t -> cbp_o/cbp_valid_o and code_valid_o after edge t+1.
// Backpressure: codeword held stable on code_valid_o until code_ready_i; new MBs ignored while busy_o.
module cbp_mb_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mb_start_i,
  input  logic        mb_i16_i,
  input  logic        blk_valid_i,
  input  logic [1:0]  blk_type_i,
  input  logic [3:0]  blk_idx_i,
  input  logic        blk_nz_i,
  input  logic        mb_done_i,
  output logic [5:0]  cbp_o,
  output logic        cbp_valid_o,
  output logic [10:0] code_bits_o,
  output logic [3:0]  code_len_o,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic        busy_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] MAP     = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  logic [1:0] state;
  logic [3:0] luma_acc;
  logic       dc_acc;
  logic       ac_acc;
  logic       i16;

  logic [1:0] chroma;
  logic [5:0] cbp_nxt;
  logic [5:0] code_num;
  logic [5:0] v;
  logic [2:0] k;

  // Intra_4x4 CBP -> codeNum, inverse of the Intra column of the 4:2:0 mapping table.
  function automatic logic [5:0] cbp_to_code(input logic [5:0] cbp);
    logic [5:0] c;
    case (cbp)
      6'd0:  c = 6'd3;   6'd1:  c = 6'd29;  6'd2:  c = 6'd30;  6'd3:  c = 6'd17;
      6'd4:  c = 6'd31;  6'd5:  c = 6'd18;  6'd6:  c = 6'd37;  6'd7:  c = 6'd8;
      6'd8:  c = 6'd32;  6'd9:  c = 6'd38;  6'd10: c = 6'd19;  6'd11: c = 6'd9;
      6'd12: c = 6'd20;  6'd13: c = 6'd10;  6'd14: c = 6'd11;  6'd15: c = 6'd2;
      6'd16: c = 6'd16;  6'd17: c = 6'd33;  6'd18: c = 6'd34;  6'd19: c = 6'd21;
      6'd20: c = 6'd35;  6'd21: c = 6'd22;  6'd22: c = 6'd39;  6'd23: c = 6'd4;
      6'd24: c = 6'd36;  6'd25: c = 6'd40;  6'd26: c = 6'd23;  6'd27: c = 6'd5;
      6'd28: c = 6'd24;  6'd29: c = 6'd6;   6'd30: c = 6'd7;   6'd31: c = 6'd1;
      6'd32: c = 6'd41;  6'd33: c = 6'd42;  6'd34: c = 6'd43;  6'd35: c = 6'd25;
      6'd36: c = 6'd44;  6'd37: c = 6'd26;  6'd38: c = 6'd46;  6'd39: c = 6'd12;
      6'd40: c = 6'd45;  6'd41: c = 6'd47;  6'd42: c = 6'd27;  6'd43: c = 6'd13;
      6'd44: c = 6'd28;  6'd45: c = 6'd14;  6'd46: c = 6'd15;  6'd47: c = 6'd0;
      // chroma never exceeds 2, so CBP 48..63 is unreachable
      default: c = 6'd0;
    endcase
    return c;
  endfunction

  // CBP assembly, table lookup and ue(v) length from the current accumulators
  always_comb begin
    chroma   = ac_acc ? 2'd2 : (dc_acc ? 2'd1 : 2'd0);
    cbp_nxt  = {chroma, luma_acc};
    code_num = cbp_to_code(cbp_nxt);
    v        = code_num + 6'd1;
    if (v[5])      k = 3'd5;
    else if (v[4]) k = 3'd4;
    else if (v[3]) k = 3'd3;
    else if (v[2]) k = 3'd2;
    else if (v[1]) k = 3'd1;
    else           k = 3'd0;
  end

  // Control FSM and nonzero-flag accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      luma_acc <= 4'd0;
      dc_acc   <= 1'b0;
      ac_acc   <= 1'b0;
      i16      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mb_start_i) begin
            state    <= COLLECT;
            luma_acc <= 4'd0;
            dc_acc   <= 1'b0;
            ac_acc   <= 1'b0;
            i16      <= mb_i16_i;
          end
        end
        COLLECT: begin
          if (mb_start_i) begin
            // restart discards the partial macroblock, including any flag this cycle
            luma_acc <= 4'd0;
            dc_acc   <= 1'b0;
            ac_acc   <= 1'b0;
            i16      <= mb_i16_i;
          end else begin
            if (blk_valid_i) begin
              case (blk_type_i)
                2'd0: luma_acc[blk_idx_i[3:2]] <= luma_acc[blk_idx_i[3:2]] | blk_nz_i;
                2'd1: dc_acc <= dc_acc | blk_nz_i;
                2'd2: ac_acc <= ac_acc | blk_nz_i;
                default: ;
              endcase
            end
            if (mb_done_i) state <= MAP;
          end
        end
        MAP: state <= i16 ? IDLE : OUT;
        OUT: if (code_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered CBP report and codeword handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbp_o        <= 6'd0;
      cbp_valid_o  <= 1'b0;
      code_bits_o  <= 11'd0;
      code_len_o   <= 4'd0;
      code_valid_o <= 1'b0;
    end else begin
      cbp_valid_o <= 1'b0;
      if (state == MAP) begin
        cbp_o       <= cbp_nxt;
        cbp_valid_o <= 1'b1;
        if (!i16) begin
          code_bits_o  <= {5'd0, v};
          code_len_o   <= {k, 1'b1};
          code_valid_o <= 1'b1;
        end
      end else if (state == OUT && code_ready_i) begin
        code_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_cbp_mb_ctrl.sv
// Directed bench for cbp_mb_ctrl with hand-computed CBP / ue(v) expectations.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Covers backpressure, Intra_16x16, restart and asynchronous reset in OUT.
module tb_cbp_mb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mb_start_i = 1'b0;
  logic        mb_i16_i = 1'b0;
  logic        blk_valid_i = 1'b0;
  logic [1:0]  blk_type_i = 2'd0;
  logic [3:0]  blk_idx_i = 4'd0;
  logic        blk_nz_i = 1'b0;
  logic        mb_done_i = 1'b0;
  logic [5:0]  cbp_o;
  logic        cbp_valid_o;
  logic [10:0] code_bits_o;
  logic [3:0]  code_len_o;
  logic        code_valid_o;
  logic        code_ready_i = 1'b1;
  logic        busy_o;

  int n_vec = 0;
  int n_bad = 0;

  cbp_mb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mb_start_i(mb_start_i), .mb_i16_i(mb_i16_i),
    .blk_valid_i(blk_valid_i), .blk_type_i(blk_type_i),
    .blk_idx_i(blk_idx_i), .blk_nz_i(blk_nz_i),
    .mb_done_i(mb_done_i),
    .cbp_o(cbp_o), .cbp_valid_o(cbp_valid_o),
    .code_bits_o(code_bits_o), .code_len_o(code_len_o),
    .code_valid_o(code_valid_o), .code_ready_i(code_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic start_mb(input logic i16);
    mb_start_i = 1'b1;
    mb_i16_i   = i16;
    @(negedge clk);
    mb_start_i = 1'b0;
    mb_i16_i   = 1'b0;
  endtask

  task automatic blk(input logic [1:0] t, input logic [3:0] idx, input logic nz);
    blk_valid_i = 1'b1;
    blk_type_i  = t;
    blk_idx_i   = idx;
    blk_nz_i    = nz;
    @(negedge clk);
    blk_valid_i = 1'b0;
    blk_nz_i    = 1'b0;
  endtask

  // mb_done pulse (any blk_* already driven are presented alongside),
  // then wait one more edge so the MAP results are visible.
  task automatic done_to_out();
    mb_done_i = 1'b1;
    @(negedge clk);
    mb_done_i   = 1'b0;
    blk_valid_i = 1'b0;
    blk_nz_i    = 1'b0;
    chk("map_busy", busy_o, 1);
    chk("map_no_cbpv_yet", cbp_valid_o, 0);
    @(negedge clk);
  endtask

  // Full non-i16 completion with ready held high.
  task automatic finish_mb(input string tag, input int e_cbp, input int e_bits, input int e_len);
    done_to_out();
    chk({tag, "_cbp"}, cbp_o, e_cbp);
    chk({tag, "_cbpv"}, cbp_valid_o, 1);
    chk({tag, "_cv"}, code_valid_o, 1);
    chk({tag, "_bits"}, code_bits_o, e_bits);
    chk({tag, "_len"}, code_len_o, e_len);
    @(negedge clk);
    chk({tag, "_cv_drop"}, code_valid_o, 0);
    chk({tag, "_cbpv_drop"}, cbp_valid_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_bits_hold"}, code_bits_o, e_bits);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_cbp", cbp_o, 0);
    chk("rst_cbpv", cbp_valid_o, 0);
    chk("rst_bits", code_bits_o, 0);
    chk("rst_len", code_len_o, 0);
    chk("rst_cv", code_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // flags ignored in IDLE must not leak into the next MB
    blk(2'd0, 4'd0, 1'b1);
    chk("idle_busy", busy_o, 0);

    // no nonzero flags: CBP 0 -> codeNum 3 -> 00100
    start_mb(1'b0);
    chk("collect_busy", busy_o, 1);
    blk(2'd0, 4'd0, 1'b0);
    blk(2'd1, 4'd0, 1'b0);
    blk(2'd2, 4'd0, 1'b0);
    finish_mb("zero", 0, 4, 5);

    // all luma + chroma AC: CBP 47 -> codeNum 0 -> "1"
    start_mb(1'b0);
    blk(2'd0, 4'd1, 1'b1);
    blk(2'd0, 4'd6, 1'b1);
    blk(2'd0, 4'd9, 1'b1);
    blk(2'd0, 4'd15, 1'b1);
    blk(2'd2, 4'd0, 1'b1);
    finish_mb("all", 47, 1, 1);

    // luma only: CBP 15 -> codeNum 2 -> 011
    start_mb(1'b0);
    for (int q = 0; q < 4; q++) blk(2'd0, 4'(q * 4), 1'b1);
    blk(2'd2, 4'd0, 1'b0);
    finish_mb("luma", 15, 3, 3);

    // luma idx 2 + chroma DC; type 3 nonzero ignored: CBP 17 -> codeNum 33
    start_mb(1'b0);
    blk(2'd0, 4'd2, 1'b1);
    blk(2'd1, 4'd0, 1'b1);
    blk(2'd3, 4'd12, 1'b1);
    finish_mb("l2dc", 17, 34, 11);

    // chroma DC only: CBP 16 -> codeNum 16
    start_mb(1'b0);
    blk(2'd1, 4'd0, 1'b1);
    finish_mb("dc", 16, 17, 9);

    // backpressure: CBP 3 -> codeNum 17 -> v 18, len 9
    start_mb(1'b0);
    blk(2'd0, 4'd0, 1'b1);
    blk(2'd0, 4'd7, 1'b1);
    code_ready_i = 1'b0;
    done_to_out();
    chk("bp_cbp", cbp_o, 3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) mb_start_i = 1'b1;
      @(negedge clk);
      mb_start_i = 1'b0;
      chk("bp_cv_hold", code_valid_o, 1);
      chk("bp_bits_hold", code_bits_o, 18);
      chk("bp_len_hold", code_len_o, 9);
      chk("bp_busy", busy_o, 1);
    end
    code_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_cv_drop", code_valid_o, 0);
    chk("bp_idle", busy_o, 0);
    @(negedge clk);
    chk("bp_no_restart", busy_o, 0);
    chk("bp_single_hs", code_valid_o, 0);

    // Intra_16x16: luma idx 5 -> CBP 2, no codeword
    start_mb(1'b1);
    blk(2'd0, 4'd5, 1'b1);
    done_to_out();
    chk("i16_cbp", cbp_o, 2);
    chk("i16_cbpv", cbp_valid_o, 1);
    chk("i16_no_cv", code_valid_o, 0);
    chk("i16_idle", busy_o, 0);
    @(negedge clk);
    chk("i16_cbpv_drop", cbp_valid_o, 0);
    chk("i16_no_cv2", code_valid_o, 0);

    // restart mid-COLLECT discards earlier luma flags
    start_mb(1'b0);
    blk(2'd0, 4'd0, 1'b1);
    blk(2'd0, 4'd4, 1'b1);
    start_mb(1'b0);
    chk("rs_no_output", cbp_valid_o, 0);
    blk(2'd0, 4'd8, 1'b0);
    finish_mb("restart", 0, 4, 5);

    // asynchronous reset while in OUT
    start_mb(1'b0);
    blk(2'd2, 4'd0, 1'b1);
    code_ready_i = 1'b0;
    done_to_out();
    chk("pre_rst_cv", code_valid_o, 1);
    chk("pre_rst_cbp", cbp_o, 32);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cbp", cbp_o, 0);
    chk("arst_bits", code_bits_o, 0);
    chk("arst_len", code_len_o, 0);
    chk("arst_cv", code_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    code_ready_i = 1'b1;
    @(negedge clk);

    // flag coincident with mb_done counted: luma idx 0 -> CBP 1 -> codeNum 29
    start_mb(1'b0);
    blk(2'd1, 4'd0, 1'b0);
    blk_valid_i = 1'b1;
    blk_type_i  = 2'd0;
    blk_idx_i   = 4'd3;
    blk_nz_i    = 1'b1;
    finish_mb("coinc", 1, 30, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cbp_mb_ctrl.md
# cbp_mb_ctrl

Per-macroblock coded_block_pattern controller for the intra-frame entropy path. It collects per-4x4-block nonzero flags from the transform/quant stage and derives the 6-bit CBP. It then maps CBP to the Intra_4x4 codeNum (H.264 Table 9-4, chroma_format_idc = 1, Intra column) and emits the ue(v) codeword to the bitstream packer over a valid/ready handshake. For Intra_16x16 macroblocks CBP is only reported, because it is folded into mb_type.

## Interface
Parameters:
- none; all widths are fixed by the standard (CBP 6 b, codeword ≤ 11 b).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mb_start_i  in  1  pulse; begin a new macroblock and clear the accumulators
- mb_i16_i  in  1  sampled with mb_start_i; 1 = Intra_16x16 (no CBP codeword)
- blk_valid_i  in  1  one residual-block flag is presented this cycle
- blk_type_i  in  2  0 = luma 4x4, 1 = chroma DC, 2 = chroma AC, 3 = ignored
- blk_idx_i  in  4  luma 4x4 index; [3:2] selects the 8x8 quadrant; ignored for chroma
- blk_nz_i  in  1  block has ≥1 nonzero coefficient
- mb_done_i  in  1  pulse; all blocks of the macroblock have been delivered
- cbp_o  out  6  registered CBP {chroma[1:0], luma[3:0]}
- cbp_valid_o  out  1  one-cycle pulse when cbp_o updates
- code_bits_o  out  11  ue(v) codeword, right-aligned; leading zeros implicit
- code_len_o  out  4  codeword length, 1..11
- code_valid_o  out  1  codeword valid
- code_ready_i  in  1  packer accepts the codeword
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, COLLECT, MAP, OUT.
- IDLE: mb_start_i → COLLECT. On entry, clear luma_acc[3:0], dc_acc and ac_acc, and latch mb_i16_i. blk_valid_i and mb_done_i are ignored in IDLE.
- COLLECT, when blk_valid_i is high:
  - type 0: luma_acc[blk_idx_i[3:2]] |= blk_nz_i
  - type 1: dc_acc |= blk_nz_i
  - type 2: ac_acc |= blk_nz_i
  - type 3: no effect
- COLLECT, mb_start_i: restart. Accumulators clear, i16 is relatched, the state stays COLLECT, and the partial macroblock is discarded without output.
- COLLECT, mb_done_i → MAP. A block flag presented in the same cycle as mb_done_i is included.
- MAP (one cycle): register cbp_o = {chroma, luma_acc}, where chroma = ac_acc ? 2 : (dc_acc ? 1 : 0). Pulse cbp_valid_o. Compute codeNum by table lookup and register the codeword. Go to IDLE if i16, else OUT.
- ue(v) arithmetic: v = codeNum + 1 (6 b, max 48); k = floor(log2 v); code_len_o = 2k + 1; code_bits_o = v zero-extended to 11 b.
- OUT: hold code_valid_o = 1 with stable bits and length until code_ready_i is high. On the handshake cycle go to IDLE. mb_start_i is ignored in OUT and MAP, so upstream must wait for busy_o to fall.
- Any CBP input outside 0..47 cannot occur, because chroma ≤ 2.

## Timing
- Reset values: cbp_o = 0, cbp_valid_o = 0, code_bits_o = 0, code_len_o = 0, code_valid_o = 0, busy_o = 0, state = IDLE, accumulators = 0.
- If mb_done_i is sampled at edge t, then cbp_o and cbp_valid_o are valid after edge t+1, and code_valid_o rises after edge t+1 (same cycle as cbp_valid_o).
- With code_ready_i held high, code_valid_o lasts exactly one cycle, and busy_o falls the following cycle. Minimum MB turnaround is mb_done → IDLE in 3 cycles.
- code_valid_o is deasserted the cycle after the handshake. code_bits_o and code_len_o hold their last value.
- cbp_o holds until the next MAP.
- Asynchronous reset in any state forces IDLE and all reset values immediately. A pending codeword is dropped.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- No flags (all blk_nz_i = 0), not i16 → cbp_o = 0, codeNum 3, code_bits_o = 4, code_len_o = 5.
- All four luma quadrants nonzero plus one chroma AC nonzero → cbp_o = 47, code_bits_o = 1, code_len_o = 1. A second run with only luma nonzero gives cbp_o = 15, bits = 3, len = 3.
- Only luma idx 2 nonzero plus chroma DC nonzero (AC zero) → cbp_o = 17, codeNum 33, bits = 34, len = 11. Only chroma DC nonzero → cbp_o = 16, bits = 17, len = 9.
- Backpressure: hold code_ready_i = 0 for 5 cycles → code_valid_o stays high with stable bits, busy_o = 1, and a mb_start_i pulse is ignored. After release: exactly one handshake, then IDLE.
- mb_i16_i = 1 with luma idx 5 nonzero → cbp_o = 2 and cbp_valid_o pulses; code_valid_o never rises; IDLE 2 cycles after mb_done_i.
- Restart and reset:
  - mb_start_i mid-COLLECT after luma flags → new MB with no flags yields cbp_o = 0.
  - rst_n low while in OUT → all outputs 0 at once, and the next MB works normally.
  - blk_valid_i coincident with mb_done_i is counted.
